// File: rtl/fir_prog_tn_pkg.sv
// Shared constants and helpers for the programmable transposed-form FIR.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

  // Full-precision output width: product width plus growth for summing TAPS terms.
  function automatic int fir_ow(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Default reset coefficients, h[0] in the least significant byte.
  localparam logic [31:0] H_INIT_DEFAULT = {8'd8, 8'd7, 8'd6, 8'd5};

  // Bit offset of coefficient k inside a packed coefficient bank.
  function automatic int coef_lsb(input int k, input int cw);
    return k * cw;
  endfunction

endpackage

// File: rtl/fir_prog_tn_tap_mac.sv
// One transposed-form tap: registered partial sum p = sum_in + x*h.
// Latency: 1 cycle from an enabled sample to sum_out.
// Backpressure: none; holds its value whenever en is low, clr wins over en.
module fir_tap_mac #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 18,
  parameter bit LAST = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] x,
  input  logic [CW-1:0] h,
  input  logic [OW-1:0] sum_in,
  input  logic          en,
  input  logic          clr,
  output logic [OW-1:0] sum_out
);

  logic [OW-1:0] prod;
  logic [OW-1:0] add_in;

  // The last tap starts the chain, so it has nothing to add in.
  assign add_in = LAST ? '0 : sum_in;
  assign prod   = OW'(x) * OW'(h);

  // Partial-sum register: cleared by flush, advanced only on an accepted sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_out <= '0;
    end else if (clr) begin
      sum_out <= '0;
    end else if (en) begin
      sum_out <= add_in + prod;
    end
  end

endmodule

// File: rtl/fir_prog_tn.sv
// N-tap transposed FIR with shadow/active coefficient banks and atomic commit.
// Latency: 1 cycle, sample accepted at edge t appears on y/out_valid after edge t.
// Backpressure: none; accepts one sample per cycle, gaps hold state, flush drops the sample.
module fir_prog_tn
  import fir_pkg::*;
#(
  parameter int                   DW     = 8,
  parameter int                   CW     = 8,
  parameter int                   TAPS   = 4,
  parameter int                   OW     = fir_ow(DW, CW, TAPS),
  parameter logic [TAPS*CW-1:0]   H_INIT = H_INIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DW-1:0]             x,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]             coef_data,
  input  logic                      coef_commit,
  output logic                      out_valid,
  output logic [OW-1:0]             y
);

  logic [TAPS*CW-1:0] shadow;
  logic [TAPS*CW-1:0] active;
  logic [OW-1:0]      p [0:TAPS-2];
  logic [OW-1:0]      y_next;
  logic               accept;

  assign accept = in_valid && !flush;

  // Shadow takes host writes; commit copies the pre-edge shadow so a same-cycle write is not committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= H_INIT;
      active <= H_INIT;
    end else begin
      if (coef_we && (int'(coef_addr) < TAPS)) begin
        shadow[coef_lsb(int'(coef_addr), CW) +: CW] <= coef_data;
      end
      if (coef_commit) begin
        active <= shadow;
      end
    end
  end

  // Taps 1..TAPS-1 hold the partial sums; tap TAPS-1 begins the chain.
  for (genvar k = 1; k < TAPS; k++) begin : g_tap
    logic [OW-1:0] chain_in;
    if (k == TAPS - 1) begin : g_last
      assign chain_in = '0;
    end else begin : g_mid
      assign chain_in = p[k];
    end

    fir_tap_mac #(
      .DW   (DW),
      .CW   (CW),
      .OW   (OW),
      .LAST (k == TAPS - 1)
    ) u_tap (
      .clk     (clk),
      .reset   (reset),
      .x       (x),
      .h       (active[coef_lsb(k, CW) +: CW]),
      .sum_in  (chain_in),
      .en      (in_valid),
      .clr     (flush),
      .sum_out (p[k-1])
    );
  end

  // Tap 0 adds combinationally straight into the output register.
  assign y_next = p[0] + (OW'(x) * OW'(active[coef_lsb(0, CW) +: CW]));

  // Output register and valid pulse; flush clears and suppresses the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      y         <= y_next;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_prog_tn.sv
// Directed bench for fir_prog_tn with hand-computed expected outputs.
// Latency: checks y/out_valid 1 time unit after each active edge.
// Backpressure: n/a.
module tb_fir_prog_tn;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  x;
  logic        flush;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        coef_commit;
  logic        out_valid;
  logic [17:0] y;

  int n_cmp = 0;
  int n_err = 0;

  fir_prog_tn dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .x           (x),
    .flush       (flush),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .out_valid   (out_valid),
    .y           (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then return inputs to idle.
  task automatic cyc(input logic v, input logic [7:0] xv, input logic fl,
                     input logic we, input logic [1:0] ad, input logic [7:0] dat,
                     input logic cm);
    in_valid    = v;
    x           = xv;
    flush       = fl;
    coef_we     = we;
    coef_addr   = ad;
    coef_data   = dat;
    coef_commit = cm;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    x           = '0;
    flush       = 1'b0;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    coef_commit = 1'b0;
  endtask

  task automatic smp(input logic [7:0] xv, input logic [17:0] exp, input string tag);
    cyc(1'b1, xv, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    chk(tag, y, exp);
    chk({tag, "_vld"}, {17'd0, out_valid}, 18'd1);
  endtask

  task automatic do_flush();
    cyc(1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; x = '0; flush = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    #2;
    chk("rst_y", y, 18'd0);
    chk("rst_vld", {17'd0, out_valid}, 18'd0);
    @(negedge clk);
    reset = 1'b1;

    // Impulse with reset coefficients 5,6,7,8.
    smp(8'd1, 18'd5, "imp0");
    smp(8'd0, 18'd6, "imp1");
    smp(8'd0, 18'd7, "imp2");
    smp(8'd0, 18'd8, "imp3");
    smp(8'd0, 18'd0, "imp4");

    // Full-scale step.
    smp(8'd255, 18'd1275, "step0");
    smp(8'd255, 18'd2805, "step1");
    smp(8'd255, 18'd4590, "step2");
    smp(8'd255, 18'd6630, "step3");
    smp(8'd255, 18'd6630, "step4");
    do_flush();
    chk("flush_y", y, 18'd0);
    chk("flush_vld", {17'd0, out_valid}, 18'd0);

    // Impulse with a 3-cycle gap: y holds, valid only pulses on samples.
    smp(8'd1, 18'd5, "gap0");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      chk("gap_hold_y", y, 18'd5);
      chk("gap_hold_vld", {17'd0, out_valid}, 18'd0);
    end
    smp(8'd0, 18'd6, "gap1");
    smp(8'd0, 18'd7, "gap2");
    smp(8'd0, 18'd8, "gap3");

    // Flush together with a valid sample: sample dropped, pipe cleared.
    smp(8'd1, 18'd5, "fv_pre");
    cyc(1'b1, 8'd255, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    chk("fv_y", y, 18'd0);
    chk("fv_vld", {17'd0, out_valid}, 18'd0);
    smp(8'd0, 18'd0, "fv_post");

    // Shadow write without commit leaves active unchanged.
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 2'd0, 8'd1, 1'b0);
    smp(8'd1, 18'd5, "nocommit");
    smp(8'd0, 18'd6, "nocommit_h1");
    do_flush();
    // Write h0=2 and commit in one cycle, with a sample: old h0=5 used.
    cyc(1'b1, 8'd1, 1'b0, 1'b1, 2'd0, 8'd2, 1'b1);
    chk("wc_same_y", y, 18'd5);
    do_flush();
    // Committed value is the pre-edge shadow (1), not the same-cycle write (2).
    smp(8'd1, 18'd1, "wc_committed");
    smp(8'd0, 18'd6, "wc_committed_h1");
    do_flush();
    // Commit with a sample in the same cycle: sample still uses h0=1.
    cyc(1'b1, 8'd1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    chk("commit_cycle_y", y, 18'd1);
    do_flush();
    smp(8'd1, 18'd2, "after_commit");
    do_flush();

    // Worst case: all coefficients 255, full-scale input.
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'd0, 1'b0, 1'b1, 2'(k), 8'd255, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    do_flush();
    smp(8'd255, 18'd65025, "worst0");
    smp(8'd255, 18'd130050, "worst1");
    smp(8'd255, 18'd195075, "worst2");
    smp(8'd255, 18'd260100, "worst3");

    // Asynchronous reset pulse between edges.
    #3;
    reset = 1'b0;
    #1;
    chk("arst_y", y, 18'd0);
    chk("arst_vld", {17'd0, out_valid}, 18'd0);
    #2;
    reset = 1'b1;
    smp(8'd1, 18'd5, "post_rst0");
    smp(8'd0, 18'd6, "post_rst1");
    smp(8'd0, 18'd7, "post_rst2");
    smp(8'd0, 18'd8, "post_rst3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_prog_tn.md
# fir_prog_tn

Parametrised N-tap transposed-form FIR filter with run-time programmable coefficients, a sample-valid handshake and a registered full-precision output. It replaces the fixed 4-tap, fixed-coefficient filter in the DSP datapath. It sits between the sample source (ADC capture or test pattern) and downstream decimation or accumulation logic. Coefficients are written by a host-side register interface into a shadow bank. They take effect atomically on commit.

## Interface
- `DW`, 8, input sample width (unsigned).
- `CW`, 8, coefficient width (unsigned).
- `TAPS`, 4, number of taps, ≥ 2.
- `OW`, `DW+CW+$clog2(TAPS)`, output width. Must not be overridden smaller.
- `H_INIT`, `{8'd8,8'd7,8'd6,8'd5}`, packed reset coefficients. `h[k]` is at bits `[k*CW +: CW]`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `x` holds a new sample this cycle.
- `x`  in  DW  input sample.
- `flush`  in  1  synchronous clear of filter state (delay line and output).
- `coef_we`  in  1  write `coef_data` into shadow bank at `coef_addr`.
- `coef_addr`  in  `$clog2(TAPS)`  shadow coefficient index.
- `coef_data`  in  CW  shadow coefficient value.
- `coef_commit`  in  1  copy the whole shadow bank into the active bank.
- `out_valid`  out  1  `y` holds a new result. One-cycle pulse per accepted sample.
- `y`  out  OW  filter output.

## Operation
- Computes `y[n] = Σ h[k]·x[n−k]`, k = 0..TAPS−1, unsigned, full precision. No rounding and no saturation; OW guarantees no overflow.
- The state advances only on an accepted sample (`in_valid`=1, `flush`=0), using transposed partial sums `p[0..TAPS−2]`:
  - `p[TAPS−2] <= x·h[TAPS−1]`
  - `p[k] <= p[k+1] + x·h[k+1]`
  - `y <= p[0] + x·h[0]`
  - `out_valid <= 1`
- No accepted sample: all `p`, and `y`, hold their values; `out_valid <= 0`.
- `flush`=1: all `p` and `y` are set to 0 and `out_valid <= 0`. Coefficients are untouched. Flush wins over `in_valid`; the sample is dropped.
- Coefficient banks:
  - `coef_we`: `shadow[coef_addr] <= coef_data`. An out-of-range address (only possible when TAPS is not a power of 2) is ignored.
  - `coef_commit`: `active <= shadow`, using the pre-edge shadow contents. A `coef_we` in the same cycle lands in shadow only and is not committed.
  - Arithmetic always uses the pre-edge `active` bank. A sample accepted in the commit cycle uses the old coefficients; the new set applies from the next sample on.
  - Committing with samples in flight is allowed. Partial sums already in the pipe keep their old-coefficient contributions, so there is a TAPS−1 sample transient. Software flushes if that is unacceptable.

## Timing
- Latency: 1 cycle. A sample accepted at edge t gives `y` and `out_valid` valid after edge t, together with its contribution to all `p`.
- Throughput: 1 sample per cycle. Gaps in `in_valid` of any length are allowed with no state loss.
- Reset (`reset`=0, asynchronous):
  - `p`=0, `y`=0, `out_valid`=0.
  - `shadow`=`active`=`H_INIT`.
  - Reset asserted mid-stream discards all state immediately.
  - First accepted sample after deassertion gives `y = x·h[0]`.
- Critical path: one CW×DW multiply plus one OW-bit add per tap. No multiplier sharing.

## Structure
- Shared package `fir_pkg`:
  - `OW` derivation helper (clog2).
  - Default `H_INIT` constant.
  - Packed-coefficient index macro/function.
- One sub-module `fir_tap_mac`, instantiated once per tap via generate:
  - Parameters: `DW`, `CW`, `OW`, `LAST` (no add-in).
  - Inputs: `x`, `h`, `sum_in`, `en`, `clr`.
  - Output: `sum_out` (registered `p`).
  - Tap 0's adder is combinational into the top-level `y` register.
- Top level owns the shadow and active banks, commit and flush logic, and `out_valid`.

## Test plan
- Reset defaults, impulse: x = 1, 0, 0, 0, 0, all valid → y = 5, 6, 7, 8, 0, with `out_valid` high each cycle.
- Step at maximum: x = 255 held for 5 valid cycles → y = 1275, 2805, 4590, 6630, 6630.
- Valid gaps: impulse x = 1, then in_valid=0 for 3 cycles, then x = 0 ×3 → y = 5 (held through the gap, `out_valid` pulses only when valid), then 6, 7, 8.
- Worst case: commit all h = 255, flush, then x = 255 for 4 samples → final y = 260100; no overflow at OW = 18.
- Commit/write hazards:
  - Write `h[0]` = 1 with no commit → output unchanged.
  - Write and commit in the same cycle → old value still active.
  - Commit the next cycle; an impulse in the commit cycle gives y = 5; a later impulse gives y = 1.
- Flush/reset mid-stream:
  - `flush` together with `in_valid`: sample dropped, y = 0, `out_valid` = 0.
  - Async `reset` pulse between edges: outputs 0 immediately and coefficients return to 5, 6, 7, 8.
